// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the sequential ALU.
package seq_alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_NOT  = 5'b00101;
  localparam logic [4:0] OP_MUL  = 5'b00110;
  localparam logic [4:0] OP_DIV  = 5'b00111;
  localparam logic [4:0] OP_SLL  = 5'b01000;
  localparam logic [4:0] OP_SRL  = 5'b01001;
  localparam logic [4:0] OP_PASS = 5'b01010;
  localparam logic [4:0] OP_SRA  = 5'b01011;
  localparam logic [4:0] OP_REM  = 5'b01100;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  function automatic logic is_iterative(input logic [4:0] sel);
    return (sel == OP_MUL) || (sel == OP_DIV) || (sel == OP_REM);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one bit per step.
module seq_alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_mul,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last_c,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;
  logic [WIDTH-1:0] r_dvsr, r_quo, r_rem;
  logic [WIDTH:0]   w_shift, w_diff;
  logic             w_fits;

  // Partial remainder needs one extra bit before the trial subtraction.
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_dvsr};
  assign w_fits   = ~w_diff[WIDTH];
  assign o_last_c = (r_cnt == CW'(WIDTH - 1));
  assign o_acc    = r_acc;
  assign o_quo    = r_quo;
  assign o_rem    = r_rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_dvsr   <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
      if (i_mul) begin
        r_mcand  <= i_a;
        r_mplier <= i_b;
        r_acc    <= '0;
      end else begin
        r_quo  <= i_a;
        r_dvsr <= i_b;
        r_rem  <= '0;
      end
    end else if (i_step) begin
      r_cnt <= r_cnt + CW'(1);
      if (i_mul) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end else begin
        // Dividend bits shift out of r_quo as quotient bits shift in.
        r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], w_fits};
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake; MUL/DIV/REM run iteratively.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] f,
  output logic             a_equal_b,
  output logic             a_bigger_b,
  output logic             a_bigger_equal_b,
  output logic             a_smaller_b,
  output logic             a_smaller_equal_b,
  output logic             div_zero,
  output logic             op_err
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e           r_state;
  logic [4:0]       r_op;
  logic             r_in_ready, r_out_valid, r_div_zero, r_op_err;
  logic [WIDTH-1:0] r_f;
  logic             r_eq, r_bg, r_bge, r_sm, r_sme;

  logic             w_accept, w_start, w_mul, w_step, w_last, w_big;
  logic             w_complete, w_dz, w_err, w_zero;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_res, w_acc, w_quo, w_rem;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_start  = w_accept && is_iterative(sel) && ((sel == OP_MUL) || (b != '0));
  assign w_mul    = (r_state == IDLE) ? (sel == OP_MUL) : (r_state == MUL);
  assign w_step   = (r_state == MUL) || (r_state == DIV);
  assign w_big    = |b[WIDTH-1:SHW];
  assign w_sh     = b[SHW-1:0];
  assign w_zero   = (w_res == '0);

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_start),
    .i_mul    (w_mul),
    .i_step   (w_step),
    .i_a      (a),
    .i_b      (b),
    .o_last_c (w_last),
    .o_acc    (w_acc),
    .o_quo    (w_quo),
    .o_rem    (w_rem)
  );

  // Result of whichever op completes this cycle (single-cycle or DONE).
  always_comb begin
    w_res      = '0;
    w_dz       = 1'b0;
    w_err      = 1'b0;
    w_complete = 1'b0;
    if (r_state == DONE) begin
      w_complete = 1'b1;
      case (r_op)
        OP_MUL:  w_res = w_acc;
        OP_REM:  w_res = w_rem;
        default: w_res = w_quo;
      endcase
    end else if (w_accept && !w_start) begin
      w_complete = 1'b1;
      case (sel)
        OP_ADD:  w_res = a + b;
        OP_SUB:  w_res = a - b;
        OP_AND:  w_res = a & b;
        OP_OR:   w_res = a | b;
        OP_XOR:  w_res = a ^ b;
        OP_NOT:  w_res = ~a;
        OP_PASS: w_res = b;
        OP_SLL:  w_res = w_big ? '0 : (a << w_sh);
        OP_SRL:  w_res = w_big ? '0 : (a >> w_sh);
        OP_SRA:  w_res = w_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> w_sh);
        OP_DIV: begin
          w_dz  = 1'b1;
          w_res = '1;
        end
        OP_REM: begin
          w_dz  = 1'b1;
          w_res = a;
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_f         <= '0;
      r_eq        <= 1'b0;
      r_bg        <= 1'b0;
      r_bge       <= 1'b0;
      r_sm        <= 1'b0;
      r_sme       <= 1'b0;
      r_div_zero  <= 1'b0;
      r_op_err    <= 1'b0;
    end else begin
      r_out_valid <= w_complete;
      if (w_complete) begin
        r_f        <= w_res;
        r_eq       <= w_zero;
        r_bg       <= !w_res[WIDTH-1] && !w_zero;
        r_bge      <= (!w_res[WIDTH-1] && !w_zero) || w_zero;
        r_sm       <= w_res[WIDTH-1];
        r_sme      <= w_res[WIDTH-1] || w_zero;
        r_div_zero <= w_dz;
        r_op_err   <= w_err;
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_op       <= sel;
            r_state    <= (sel == OP_MUL) ? MUL : DIV;
            r_in_ready <= 1'b0;
          end
        end
        MUL, DIV: begin
          if (w_last) r_state <= DONE;
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready          = r_in_ready;
  assign out_valid         = r_out_valid;
  assign f                 = r_f;
  assign a_equal_b         = r_eq;
  assign a_bigger_b        = r_bg;
  assign a_bigger_equal_b  = r_bge;
  assign a_smaller_b       = r_sm;
  assign a_smaller_equal_b = r_sme;
  assign div_zero          = r_div_zero;
  assign op_err            = r_op_err;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expected results queued at accept, checked at out_valid.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   sel;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic [W-1:0] f;
  logic         a_equal_b, a_bigger_b, a_bigger_equal_b, a_smaller_b, a_smaller_equal_b;
  logic         div_zero, op_err;

  typedef struct {
    string        tag;
    logic [W-1:0] f;
    logic         dz;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   ov_count = 0;
  int   waits;

  seq_alu #(.WIDTH(W)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .sel               (sel),
    .a                 (a),
    .b                 (b),
    .out_valid         (out_valid),
    .f                 (f),
    .a_equal_b         (a_equal_b),
    .a_bigger_b        (a_bigger_b),
    .a_bigger_equal_b  (a_bigger_equal_b),
    .a_smaller_b       (a_smaller_b),
    .a_smaller_equal_b (a_smaller_equal_b),
    .div_zero          (div_zero),
    .op_err            (op_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // {equal, bigger, bigger_equal, smaller, smaller_equal} as defined on f.
  function automatic logic [4:0] exp_flags(input logic [W-1:0] r);
    logic eq, bg, sm;
    eq = (r == '0);
    bg = !r[W-1] && (r != '0);
    sm = r[W-1];
    return {eq, bg, bg | eq, sm, sm | eq};
  endfunction

  function automatic exp_t model(input logic [4:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.tag = $sformatf("op%0h", s);
    e.f = '0; e.dz = 1'b0; e.err = 1'b0; e.cyc = 0;
    case (s)
      OP_ADD:  e.f = x + y;
      OP_SUB:  e.f = x - y;
      OP_AND:  e.f = x & y;
      OP_OR:   e.f = x | y;
      OP_XOR:  e.f = x ^ y;
      OP_NOT:  e.f = ~x;
      OP_PASS: e.f = y;
      OP_MUL:  e.f = W'(64'(x) * 64'(y));
      OP_DIV:  if (y == 0) begin e.f = '1; e.dz = 1'b1; end else e.f = x / y;
      OP_REM:  if (y == 0) begin e.f = x;  e.dz = 1'b1; end else e.f = x % y;
      OP_SLL:  e.f = (y >= W) ? '0 : (x << y);
      OP_SRL:  e.f = (y >= W) ? '0 : (x >> y);
      OP_SRA:  e.f = (y >= W) ? {W{x[W-1]}} : W'($signed(x) >>> y);
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Hold a request until accepted; queue its expectation with the expected out_valid cycle.
  task automatic drive(input logic [4:0] s, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int n_wait);
    exp_t e;
    int   n;
    logic iter;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; sel = s; a = x; b = y;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
      a = $urandom; b = $urandom;
      a = x; b = y;
    end
    n_wait = n;
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    e = model(s, x, y);
    iter = (s == OP_MUL) || (((s == OP_DIV) || (s == OP_REM)) && (y != 0));
    e.cyc = cyc + 1 + (iter ? W + 1 : 0);
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", 64'(q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      ov_count++;
      if (q.size() == 0) begin
        check("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        mon_e = q.pop_front();
        check({mon_e.tag, "_f"}, 64'(f), 64'(mon_e.f));
        check({mon_e.tag, "_flags"},
              64'({a_equal_b, a_bigger_b, a_bigger_equal_b, a_smaller_b, a_smaller_equal_b}),
              64'(exp_flags(mon_e.f)));
        check({mon_e.tag, "_div_zero"}, 64'(div_zero), 64'(mon_e.dz));
        check({mon_e.tag, "_op_err"}, 64'(op_err), 64'(mon_e.err));
        check({mon_e.tag, "_latency"}, 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ov_before;
    logic [4:0]   rs;
    logic [W-1:0] ra, rb;
    reset = 1'b1; in_valid = 1'b0; sel = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_f", 64'(f), 64'd0);
    check("rst_flags", 64'({a_equal_b, a_bigger_b, a_bigger_equal_b, a_smaller_b,
                            a_smaller_equal_b, div_zero, op_err}), 64'd0);

    drive(OP_ADD, 32'd5, 32'd7, waits);
    drive(OP_SUB, 32'd3, 32'd9, waits);
    drive(OP_MUL, 32'h0001_0000, 32'h0001_0001, waits);
    drive(OP_ADD, 32'h0000_AAAA, 32'd1, waits);
    check("mul_busy_cycles", 64'(waits), 64'(W + 1));
    drive(OP_DIV, 32'd100, 32'd7, waits);
    drive(OP_REM, 32'd100, 32'd7, waits);
    drive(OP_DIV, 32'd9, 32'd0, waits);
    drive(OP_REM, 32'd9, 32'd0, waits);
    drive(OP_SRA, 32'h8000_0000, 32'd4, waits);
    drive(OP_SRA, 32'h8000_0000, 32'd40, waits);
    drive(OP_SRL, 32'h8000_0000, 32'd31, waits);
    drive(OP_SLL, 32'd1, 32'd32, waits);
    drive(OP_NOT, 32'h0F0F_0000, 32'd0, waits);
    drive(OP_PASS, 32'd1, 32'h7FFF_FFFF, waits);
    drive(5'b11111, 32'd3, 32'd4, waits);
    drive(OP_ADD, 32'd2, 32'd3, waits);
    drain();

    for (int i = 0; i < 24; i++) begin
      rs = 5'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if ((rs == OP_SLL || rs == OP_SRL || rs == OP_SRA) && $urandom_range(0, 1) == 1)
        rb = W'($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) rb = '0;
      drive(rs, ra, rb, waits);
    end
    drain();

    // Reset in the middle of a DIV aborts it with no result.
    drive(OP_ADD, 32'h1234, 32'd1, waits);
    drive(OP_DIV, 32'd100, 32'd7, waits);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    q.delete();
    ov_before = ov_count;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_f", 64'(f), 64'd0);
    check("abort_flags", 64'({a_equal_b, a_bigger_b, a_bigger_equal_b, a_smaller_b,
                              a_smaller_equal_b, div_zero, op_err}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (W + 8) @(negedge clk);
    check("abort_no_out_valid", 64'(ov_count), 64'(ov_before));
    drive(OP_ADD, 32'd1, 32'd1, waits);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
